// File: rtl/systolic_seq.sv
// Control sequencer for a DIM x DIM tpumac systolic array. It runs CLEAR, then FEED, then READ, then a one-cycle DONE.
// Optional SYSTOLIC_SEQ_STALL_EN adds a stall input that freezes the FEED phase.
module systolic_seq #(
  parameter int DIM  = 8,
  parameter int CNTW = $clog2(3*DIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
`ifdef SYSTOLIC_SEQ_STALL_EN
  input  logic                    stall,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    sa_en,
  output logic                    sa_wren,
  output logic [$clog2(DIM)-1:0]  c_row,
  output logic                    c_rd_valid,
  output logic [CNTW-1:0]         step,
  output logic [DIM-1:0]          a_valid,
  output logic [DIM-1:0]          b_valid
);

  localparam int RW = $clog2(DIM);
  localparam logic [CNTW-1:0] CNT_ROW_LAST  = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] CNT_FEED_LAST = CNTW'(3*DIM - 3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_READ,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  int              cnt_i;

`ifdef SYSTOLIC_SEQ_STALL_EN
  // Marks a FEED cycle that repeats the previous step with the array frozen.
  logic frozen_q, frozen_d;
`endif

  // NOTE: every output of an always_comb gets a default first, so that no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef SYSTOLIC_SEQ_STALL_EN
    frozen_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_ROW_LAST) begin
          state_d = ST_FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_FEED: begin
`ifdef SYSTOLIC_SEQ_STALL_EN
        if (stall) frozen_d = 1'b1;
        else
`endif
        if (cnt_q == CNT_FEED_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_ROW_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SYSTOLIC_SEQ_STALL_EN
  always_ff @(posedge clk) begin
    if (rst) frozen_q <= 1'b0;
    else     frozen_q <= frozen_d;
  end
`endif

  assign cnt_i = int'(cnt_q);

  // Outputs depend only on registered state, so start and stall never reach an output in the same cycle.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    sa_en      = 1'b0;
    sa_wren    = 1'b0;
    c_row      = '0;
    c_rd_valid = 1'b0;
    step       = '0;
    a_valid    = '0;
    b_valid    = '0;
    case (state_q)
      ST_CLEAR: begin
        busy    = 1'b1;
        sa_en   = 1'b1;
        sa_wren = 1'b1;
        c_row   = cnt_q[RW-1:0];
      end
      ST_FEED: begin
        busy  = 1'b1;
`ifdef SYSTOLIC_SEQ_STALL_EN
        sa_en = ~frozen_q;
`else
        sa_en = 1'b1;
`endif
        step  = cnt_q;
        // Lane r carries element (step - r), which exists only for the DIM steps starting at step r.
        for (int r = 0; r < DIM; r++) begin
          a_valid[r] = (cnt_i >= r) && (cnt_i < r + DIM);
          b_valid[r] = (cnt_i >= r) && (cnt_i < r + DIM);
        end
      end
      ST_READ: begin
        busy       = 1'b1;
        c_rd_valid = 1'b1;
        c_row      = cnt_q[RW-1:0];
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq. A DIM=8 instance is compared with a cycle-timeline model and a table of
// known values. A DIM=2 instance drives a behavioural PE array, and its readback is compared with a matrix product.
module tb_systolic_seq;

  localparam int D   = 8;
  localparam int RW  = $clog2(D);
  localparam int CW  = $clog2(3*D);
  localparam int D2  = 2;
  localparam int RW2 = $clog2(D2);
  localparam int CW2 = $clog2(3*D2);

  logic clk;
  logic rst, start, start2;
`ifdef SYSTOLIC_SEQ_STALL_EN
  logic stall;
`endif

  logic          busy, done, sa_en, sa_wren, c_rd_valid;
  logic [RW-1:0] c_row;
  logic [CW-1:0] step;
  logic [D-1:0]  a_valid, b_valid;

  logic           s2_busy, s2_done, s2_sa_en, s2_sa_wren, s2_c_rd_valid;
  logic [RW2-1:0] s2_c_row;
  logic [CW2-1:0] s2_step;
  logic [D2-1:0]  s2_a_valid, s2_b_valid;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  systolic_seq #(.DIM(D)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef SYSTOLIC_SEQ_STALL_EN
    .stall      (stall),
`endif
    .busy       (busy),
    .done       (done),
    .sa_en      (sa_en),
    .sa_wren    (sa_wren),
    .c_row      (c_row),
    .c_rd_valid (c_rd_valid),
    .step       (step),
    .a_valid    (a_valid),
    .b_valid    (b_valid)
  );

  systolic_seq #(.DIM(D2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
`ifdef SYSTOLIC_SEQ_STALL_EN
    .stall      (1'b0),
`endif
    .busy       (s2_busy),
    .done       (s2_done),
    .sa_en      (s2_sa_en),
    .sa_wren    (s2_sa_wren),
    .c_row      (s2_c_row),
    .c_rd_valid (s2_c_rd_valid),
    .step       (s2_step),
    .a_valid    (s2_a_valid),
    .b_valid    (s2_b_valid)
  );

  // ---------------- behavioural DIM=2 array (A flows right, B flows down) ----------------
  int unsigned ma [D2][D2];
  int unsigned mb [D2][D2];
  int unsigned pe_a [D2][D2];
  int unsigned pe_b [D2][D2];
  int unsigned pe_c [D2][D2];
  int unsigned in_a [D2][D2];
  int unsigned in_b [D2][D2];

  always_comb begin
    for (int i = 0; i < D2; i++) begin
      for (int j = 0; j < D2; j++) begin
        in_a[i][j] = 0;
        in_b[i][j] = 0;
        if (j == 0) in_a[i][j] = s2_a_valid[i] ? ma[i][int'(s2_step) - i] : 0;
        else        in_a[i][j] = pe_a[i][j-1];
        if (i == 0) in_b[i][j] = s2_b_valid[j] ? mb[int'(s2_step) - j][j] : 0;
        else        in_b[i][j] = pe_b[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    if (s2_sa_en) begin
      for (int i = 0; i < D2; i++) begin
        for (int j = 0; j < D2; j++) begin
          pe_a[i][j] <= in_a[i][j];
          pe_b[i][j] <= in_b[i][j];
          if (s2_sa_wren && int'(s2_c_row) == i) pe_c[i][j] <= 0;
          else                                  pe_c[i][j] <= pe_c[i][j] + in_a[i][j] * in_b[i][j];
        end
      end
    end
  end

  // ---------------- DIM=8 timeline model ----------------
  typedef struct packed {
    logic          busy;
    logic          done;
    logic          sa_en;
    logic          sa_wren;
    logic          c_rd_valid;
    logic [RW-1:0] c_row;
    logic [CW-1:0] step;
    logic [D-1:0]  a_valid;
    logic [D-1:0]  b_valid;
  } outs_t;

  typedef struct {
    int           cyc;
    logic         en;
    logic         wren;
    logic         rdv;
    logic         dn;
    int           row;
    int           stp;
    logic [D-1:0] av;
  } vec_t;

  outs_t trace [64];

  // t counts cycles after the edge that sampled start; stalled cycles insert sl frozen copies of step sa.
  function automatic outs_t model(input int t, input int sa, input int sl);
    outs_t o;
    int    f, l, r, s;
    o = '0;
    l = 3*D - 2 + sl;
    f = t - (D + 1);
    r = f - l;
    if (t >= 1 && t <= D) begin
      o.busy    = 1'b1;
      o.sa_en   = 1'b1;
      o.sa_wren = 1'b1;
      o.c_row   = RW'(t - 1);
    end else if (f >= 0 && f < l) begin
      o.busy = 1'b1;
      if (sl > 0 && f > sa && f <= sa + sl) begin
        s = sa;
      end else begin
        o.sa_en = 1'b1;
        s = (sl > 0 && f > sa + sl) ? f - sl : f;
      end
      o.step = CW'(s);
      for (int i = 0; i < D; i++) begin
        o.a_valid[i] = (s >= i) && (s <= i + D - 1);
        o.b_valid[i] = (s >= i) && (s <= i + D - 1);
      end
    end else if (r >= 0 && r < D) begin
      o.busy       = 1'b1;
      o.c_rd_valid = 1'b1;
      o.c_row      = RW'(r);
    end else if (r == D) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.busy       = busy;
    o.done       = done;
    o.sa_en      = sa_en;
    o.sa_wren    = sa_wren;
    o.c_rd_valid = c_rd_valid;
    o.c_row      = c_row;
    o.step       = step;
    o.a_valid    = a_valid;
    o.b_valid    = b_valid;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_outs(input string tag, input outs_t a, input outs_t e);
    check({tag, ".busy"},    32'(a.busy),       32'(e.busy));
    check({tag, ".done"},    32'(a.done),       32'(e.done));
    check({tag, ".sa_en"},   32'(a.sa_en),      32'(e.sa_en));
    check({tag, ".sa_wren"}, 32'(a.sa_wren),    32'(e.sa_wren));
    check({tag, ".rd_vld"},  32'(a.c_rd_valid), 32'(e.c_rd_valid));
    check({tag, ".c_row"},   32'(a.c_row),      32'(e.c_row));
    check({tag, ".step"},    32'(a.step),       32'(e.step));
    check({tag, ".a_valid"}, 32'(a.a_valid),    32'(e.a_valid));
    check({tag, ".b_valid"}, 32'(a.b_valid),    32'(e.b_valid));
  endtask

  // One full operation on the DIM=8 instance, checked every cycle through the first idle cycle after done.
  task automatic run_op(input int stall_at, input int stall_len, input int mid_start, input bit hold_start);
    int    last;
    outs_t a;
    last  = 5*D - 1 + stall_len;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    for (int t = 1; t <= last + 1; t++) begin
      if (t > 1) begin
        @(posedge clk); #1;
      end
      a = sample();
      trace[t] = a;
      compare_outs($sformatf("t%0d", t), a, model(t, stall_at, stall_len));
`ifdef SYSTOLIC_SEQ_STALL_EN
      stall = (stall_len > 0) && (t - (D + 1) >= stall_at) && (t - (D + 1) < stall_at + stall_len);
`endif
      if (!hold_start) start = (t == mid_start);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain.done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic e2e(input string tag, input int unsigned a[4], input int unsigned b[4], input int unsigned exp[4]);
    int row_idx;
    bit seen_done;
    for (int i = 0; i < D2; i++) begin
      for (int j = 0; j < D2; j++) begin
        ma[i][j] = a[i*D2 + j];
        mb[i][j] = b[i*D2 + j];
      end
    end
    start2 = 1'b1;
    @(posedge clk); #1;
    start2    = 1'b0;
    row_idx   = 0;
    seen_done = 1'b0;
    for (int t = 1; t <= 5*D2 + 2 && !seen_done; t++) begin
      if (s2_c_rd_valid) begin
        check({tag, ".busy"}, 32'(s2_busy), 32'd1);
        check({tag, ".row"}, 32'(s2_c_row), 32'(row_idx));
        for (int j = 0; j < D2; j++)
          check($sformatf("%s.c%0d%0d", tag, row_idx, j), pe_c[int'(s2_c_row)][j], exp[row_idx*D2 + j]);
        row_idx++;
      end
      if (s2_done) seen_done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check({tag, ".nrows"}, 32'(row_idx), 32'(D2));
    check({tag, ".done"}, 32'(seen_done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [12];
    int unsigned ea [4];
    int unsigned eb [4];
    int unsigned ec [4];
    bit          seen;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    start2 = 1'b0;
`ifdef SYSTOLIC_SEQ_STALL_EN
    stall  = 1'b0;
`endif

    // Reset dominates start.
    repeat (2) begin
      @(posedge clk); #1;
      compare_outs("rst", sample(), '0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel.busy",  32'(busy),    32'd1);
    check("rel.wren",  32'(sa_wren), 32'd1);
    check("rel.c_row", 32'(c_row),   32'd0);
    start = 1'b0;
    drain();

    // Full run plus known-value table.
    vt[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0,  8'h00};
    vt[1]  = '{8,  1'b1, 1'b1, 1'b0, 1'b0, 7, 0,  8'h00};
    vt[2]  = '{9,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0,  8'h01};
    vt[3]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3,  8'h0F};
    vt[4]  = '{16, 1'b1, 1'b0, 1'b0, 1'b0, 0, 7,  8'hFF};
    vt[5]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8,  8'hFE};
    vt[6]  = '{23, 1'b1, 1'b0, 1'b0, 1'b0, 0, 14, 8'h80};
    vt[7]  = '{30, 1'b1, 1'b0, 1'b0, 1'b0, 0, 21, 8'h00};
    vt[8]  = '{31, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0,  8'h00};
    vt[9]  = '{38, 1'b0, 1'b0, 1'b1, 1'b0, 7, 0,  8'h00};
    vt[10] = '{39, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0,  8'h00};
    vt[11] = '{40, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0,  8'h00};
    run_op(-1, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("tbl%0d.sa_en", vt[i].cyc),   32'(trace[vt[i].cyc].sa_en),      32'(vt[i].en));
      check($sformatf("tbl%0d.wren", vt[i].cyc),    32'(trace[vt[i].cyc].sa_wren),    32'(vt[i].wren));
      check($sformatf("tbl%0d.rd_vld", vt[i].cyc),  32'(trace[vt[i].cyc].c_rd_valid), 32'(vt[i].rdv));
      check($sformatf("tbl%0d.done", vt[i].cyc),    32'(trace[vt[i].cyc].done),       32'(vt[i].dn));
      check($sformatf("tbl%0d.c_row", vt[i].cyc),   32'(trace[vt[i].cyc].c_row),      32'(vt[i].row));
      check($sformatf("tbl%0d.step", vt[i].cyc),    32'(trace[vt[i].cyc].step),       32'(vt[i].stp));
      check($sformatf("tbl%0d.a_valid", vt[i].cyc), 32'(trace[vt[i].cyc].a_valid),    32'(vt[i].av));
      check($sformatf("tbl%0d.b_valid", vt[i].cyc), 32'(trace[vt[i].cyc].b_valid),    32'(vt[i].av));
    end

    // Stray start pulses while busy are ignored.
    for (int k = 0; k < 4; k++) begin
      run_op(-1, 0, (k < 2) ? int'($urandom_range(D + 1, 4*D - 2)) : int'($urandom_range(1, 5*D - 1)), 1'b0);
    end

    // start held high: the next operation begins on the edge after the idle cycle that follows done.
    run_op(-1, 0, 0, 1'b1);
    @(posedge clk); #1;
    check("hold.busy", 32'(busy),    32'd1);
    check("hold.wren", 32'(sa_wren), 32'd1);
    start = 1'b0;
    drain();

    // Abort at FEED step 5.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    check("abort.step", 32'(step), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    compare_outs("abort", sample(), '0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (5*D) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort.quiet", 32'(seen), 32'd0);
    run_op(-1, 0, 0, 1'b0);

`ifdef SYSTOLIC_SEQ_STALL_EN
    run_op(10, 3, 0, 1'b0);
    check("stall.s19.en", 32'(trace[19].sa_en), 32'd1);
    for (int c = 20; c <= 22; c++) begin
      check($sformatf("stall.s%0d.step", c), 32'(trace[c].step),  32'd10);
      check($sformatf("stall.s%0d.en", c),   32'(trace[c].sa_en), 32'd0);
    end
    check("stall.done42", 32'(trace[42].done), 32'd1);
    for (int k = 0; k < 3; k++) run_op(int'($urandom_range(0, 3*D - 3)), int'($urandom_range(1, 4)), 0, 1'b0);
`endif

    // End-to-end DIM=2.
    ea = '{1, 2, 3, 4};
    eb = '{5, 6, 7, 8};
    ec = '{19, 22, 43, 50};
    e2e("e2e_ab", ea, eb, ec);
    ea = '{1, 0, 0, 1};
    ec = eb;
    e2e("e2e_id", ea, eb, ec);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        ea[i] = $urandom_range(0, 255);
        eb[i] = $urandom_range(0, 255);
      end
      for (int i = 0; i < D2; i++)
        for (int j = 0; j < D2; j++)
          ec[i*D2 + j] = ea[i*D2] * eb[j] + ea[i*D2 + 1] * eb[D2 + j];
      e2e($sformatf("e2e_rnd%0d", k), ea, eb, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
